// File: rtl/rgb_seq_pkg.sv
// Shared types, keyframe table and channel step helper for the RGB fade sequencer.
package rgb_seq_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t        color;
    logic [15:0] hold_ticks;
  } key_t;

  typedef key_t [15:0] key_table_t;

  typedef enum logic [1:0] {IDLE, FADE, HOLD} state_e;

  function automatic key_t make_key(input logic [7:0] r, input logic [7:0] g,
                                    input logic [7:0] b, input logic [15:0] hold);
    key_t k;
    k.color.r    = r;
    k.color.g    = g;
    k.color.b    = b;
    k.hold_ticks = hold;
    return k;
  endfunction

  // Colour-wheel corners; unused slots stay black with zero hold.
  function automatic key_table_t make_key_table(input logic [15:0] hold);
    key_table_t t;
    t    = '0;
    t[0] = make_key(8'hff, 8'h00, 8'h00, hold);
    t[1] = make_key(8'hff, 8'hff, 8'h00, hold);
    t[2] = make_key(8'h00, 8'hff, 8'h00, hold);
    t[3] = make_key(8'h00, 8'hff, 8'hff, hold);
    t[4] = make_key(8'h00, 8'h00, 8'hff, hold);
    t[5] = make_key(8'hff, 8'h00, 8'hff, hold);
    return t;
  endfunction

  localparam key_table_t DEFAULT_KEY_TABLE = make_key_table(16'd500);

  // Move one unit toward the target; saturates naturally since it stops on equality.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) begin
      return cur + 8'd1;
    end else if (cur > tgt) begin
      return cur - 8'd1;
    end
    return cur;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
module tick_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Keyframe colour sequencer: linear per-channel fades and timed holds, with duty
// values committed to the PWM stage only on period wrap.
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 12000000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned NUM_KEYS  = 6,
  parameter key_table_t  KEY_TABLE = DEFAULT_KEY_TABLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       pwm_wrap,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic [3:0] key_idx,
  output logic       busy
);

  localparam int unsigned TICK_DIV = (CLK_FREQ / TICK_HZ >= 1) ? CLK_FREQ / TICK_HZ : 1;
  localparam logic [3:0]  LAST_KEY = 4'(NUM_KEYS - 1);

  state_e      state_q, state_d;
  rgb_t        cur_q, cur_d;
  rgb_t        tgt_q, tgt_d;
  rgb_t        duty_q;
  logic [3:0]  key_idx_q, key_idx_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;

  rgb_t        stepped;
  logic [3:0]  next_key;
  logic        tick;
  logic        tick_en;
  logic        presc_clear;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (presc_clear),
    .enable (tick_en),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      tgt_q      <= '0;
      duty_q     <= '0;
      key_idx_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      key_idx_q  <= key_idx_d;
      hold_cnt_q <= hold_cnt_d;
      if (pwm_wrap) begin
        duty_q <= cur_q;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    key_idx_d  = key_idx_q;
    hold_cnt_d = hold_cnt_q;

    stepped.r = step_toward(cur_q.r, tgt_q.r);
    stepped.g = step_toward(cur_q.g, tgt_q.g);
    stepped.b = step_toward(cur_q.b, tgt_q.b);
    next_key  = (key_idx_q == LAST_KEY) ? 4'd0 : key_idx_q + 4'd1;

    if (stop) begin
      state_d    = IDLE;
      cur_d      = '0;
      key_idx_d  = '0;
      hold_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cur_d = '0;
          if (start) begin
            state_d   = FADE;
            key_idx_d = '0;
            tgt_d     = KEY_TABLE[0].color;
          end
        end
        FADE: begin
          if (tick) begin
            cur_d = stepped;
            if (stepped == tgt_q) begin
              state_d    = HOLD;
              hold_cnt_d = KEY_TABLE[key_idx_q].hold_ticks;
            end
          end
        end
        HOLD: begin
          // A zero hold leaves immediately without waiting for a tick.
          if ((hold_cnt_q == 16'd0) || (tick && (hold_cnt_q == 16'd1))) begin
            state_d    = FADE;
            key_idx_d  = next_key;
            tgt_d      = KEY_TABLE[next_key].color;
            hold_cnt_d = '0;
          end else if (tick) begin
            hold_cnt_d = hold_cnt_q - 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    tick_en     = (state_q != IDLE) && !pause;
    presc_clear = stop || ((state_q == IDLE) && start);
    key_idx     = key_idx_q;
    duty_r      = duty_q.r;
    duty_g      = duty_q.g;
    duty_b      = duty_q.b;
  end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed self-checking bench for rgb_fade_sequencer (tick every 4 cycles, 2-tick holds).
module tb_rgb_fade_sequencer;
  import rgb_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic       pwm_wrap;
  logic [7:0] duty_r;
  logic [7:0] duty_g;
  logic [7:0] duty_b;
  logic [3:0] key_idx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  rgb_fade_sequencer #(
    .CLK_FREQ  (4),
    .TICK_HZ   (1),
    .NUM_KEYS  (6),
    .KEY_TABLE (make_key_table(16'd2))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .pwm_wrap (pwm_wrap),
    .duty_r   (duty_r),
    .duty_g   (duty_g),
    .duty_b   (duty_b),
    .key_idx  (key_idx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, ending 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; pwm_wrap = 1'b1;
    step(3);
    checks++;
    if ({duty_r, duty_g, duty_b} !== 24'h0) begin
      errors++; $display("FAIL reset_duty: got %h required 000000", {duty_r, duty_g, duty_b});
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b required 0", busy);
    end
    checks++;
    if (key_idx !== 4'd0) begin
      errors++; $display("FAIL reset_key_idx: got %0d required 0", key_idx);
    end
    rst = 1'b0;
    step(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy: got %b required 0", busy);
    end
  endtask

  // Edge numbering: E1 is the edge that samples start.
  task automatic test_fade_and_hold();
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || key_idx !== 4'd0) begin
      errors++; $display("FAIL start_busy: got busy=%b key=%0d required busy=1 key=0", busy, key_idx);
    end
    step(4);  // E5: first red step lands in cur, not yet in duty
    checks++;
    if (duty_r !== 8'd0) begin
      errors++; $display("FAIL first_step_latency: got %0d required 0", duty_r);
    end
    step(1);  // E6
    checks++;
    if (duty_r !== 8'd1) begin
      errors++; $display("FAIL first_step: got %0d required 1", duty_r);
    end
    step(1015);  // E1021
    checks++;
    if (duty_r !== 8'd254) begin
      errors++; $display("FAIL red_254: got %0d required 254", duty_r);
    end
    step(1);  // E1022
    checks++;
    if ({duty_r, duty_g, duty_b} !== 24'hff0000) begin
      errors++; $display("FAIL red_full: got %h required ff0000", {duty_r, duty_g, duty_b});
    end
    step(6);  // E1028: still holding
    checks++;
    if (key_idx !== 4'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL hold_key0: got key=%0d busy=%b required key=0 busy=1", key_idx, busy);
    end
    step(1);  // E1029: hold of 2 ticks expired
    checks++;
    if (key_idx !== 4'd1) begin
      errors++; $display("FAIL hold_exit_key1: got %0d required 1", key_idx);
    end
    step(5);  // E1034
    checks++;
    if ({duty_r, duty_g, duty_b} !== 24'hff0100) begin
      errors++; $display("FAIL yellow_first_step: got %h required ff0100", {duty_r, duty_g, duty_b});
    end
  endtask

  // Key k is entered at E(1 + 1028*k): 255 fade ticks plus 2 hold ticks, 4 cycles each.
  task automatic test_full_cycle();
    step(1022);  // E2056
    for (int k = 2; k <= 6; k++) begin
      checks++;
      if (key_idx !== 4'(k - 1)) begin
        errors++; $display("FAIL key_before_%0d: got %0d required %0d", k, key_idx, k - 1);
      end
      step(1);
      checks++;
      if (key_idx !== 4'(k % 6)) begin
        errors++; $display("FAIL key_enter_%0d: got %0d required %0d", k, key_idx, k % 6);
      end
      if (k < 6) step(1027);
    end
    step(5);  // E6174
    checks++;
    if ({duty_r, duty_g, duty_b} !== 24'hff00fe) begin
      errors++; $display("FAIL magenta_to_red_start: got %h required ff00fe", {duty_r, duty_g, duty_b});
    end
    step(400);  // E6574
    checks++;
    if ({duty_r, duty_g, duty_b} !== 24'hff009a) begin
      errors++; $display("FAIL magenta_to_red_mid: got %h required ff009a", {duty_r, duty_g, duty_b});
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(1);
    checks++;
    if (busy !== 1'b0 || {duty_r, duty_g, duty_b} !== 24'h0) begin
      errors++; $display("FAIL stop_after_run: got busy=%b duty=%h required busy=0 duty=000000", busy, {duty_r, duty_g, duty_b});
    end
  endtask

  task automatic test_pause();
    pwm_wrap = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(9);  // E10: cur_r=2, prescaler at 1
    checks++;
    if (duty_r !== 8'd2) begin
      errors++; $display("FAIL pre_pause: got %0d required 2", duty_r);
    end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(10);
      checks++;
      if ({duty_r, duty_g, duty_b} !== 24'h020000) begin
        errors++; $display("FAIL paused_%0d: got %h required 020000", i, {duty_r, duty_g, duty_b});
      end
    end
    pause = 1'b0;  // E50
    step(3);  // E53
    checks++;
    if (duty_r !== 8'd2) begin
      errors++; $display("FAIL resume_latency: got %0d required 2", duty_r);
    end
    step(1);  // E54
    checks++;
    if (duty_r !== 8'd3) begin
      errors++; $display("FAIL resume_step1: got %0d required 3", duty_r);
    end
    step(4);  // E58
    checks++;
    if (duty_r !== 8'd4) begin
      errors++; $display("FAIL resume_step2: got %0d required 4", duty_r);
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(1);
  endtask

  task automatic test_wrap_gating();
    pwm_wrap = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(254);  // E255: cur_r=63 but no wrap yet
    checks++;
    if (duty_r !== 8'd0) begin
      errors++; $display("FAIL no_wrap_hold: got %0d required 0", duty_r);
    end
    pwm_wrap = 1'b1;
    step(1);  // E256
    pwm_wrap = 1'b0;
    checks++;
    if ({duty_r, duty_g, duty_b} !== 24'h3f0000) begin
      errors++; $display("FAIL wrap1_commit: got %h required 3f0000", {duty_r, duty_g, duty_b});
    end
    step(255);  // E511
    checks++;
    if (duty_r !== 8'd63) begin
      errors++; $display("FAIL between_wraps: got %0d required 63", duty_r);
    end
    pwm_wrap = 1'b1;
    step(1);  // E512
    pwm_wrap = 1'b0;
    checks++;
    if (duty_r !== 8'd127) begin
      errors++; $display("FAIL wrap2_commit: got %0d required 127", duty_r);
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic test_start_stop();
    pwm_wrap = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0 || key_idx !== 4'd0) begin
      errors++; $display("FAIL start_stop_same: got busy=%b key=%0d required busy=0 key=0", busy, key_idx);
    end
    step(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_stop_stays_idle: got %b required 0", busy);
    end
    start = 1'b1;
    step(1);  // E1
    start = 1'b0;
    step(1020);  // E1021: HOLD entered
    pwm_wrap = 1'b1;
    step(1);  // E1022
    pwm_wrap = 1'b0;
    checks++;
    if (duty_r !== 8'd255 || busy !== 1'b1) begin
      errors++; $display("FAIL hold_commit: got r=%0d busy=%b required r=255 busy=1", duty_r, busy);
    end
    step(1);  // E1023, mid-HOLD
    stop = 1'b1;
    step(1);  // E1024
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || key_idx !== 4'd0) begin
      errors++; $display("FAIL stop_in_hold: got busy=%b key=%0d required busy=0 key=0", busy, key_idx);
    end
    checks++;
    if (duty_r !== 8'd255) begin
      errors++; $display("FAIL stop_duty_held: got %0d required 255", duty_r);
    end
    step(1);
    pwm_wrap = 1'b1;
    step(1);
    pwm_wrap = 1'b0;
    checks++;
    if ({duty_r, duty_g, duty_b} !== 24'h0) begin
      errors++; $display("FAIL stop_duty_cleared: got %h required 000000", {duty_r, duty_g, duty_b});
    end
  endtask

  task automatic test_async_reset_mid_fade();
    pwm_wrap = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(100);  // E101: duty holds cur from E97
    checks++;
    if (duty_r !== 8'd24 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_fade: got r=%0d busy=%b required r=24 busy=1", duty_r, busy);
    end
    #2;
    rst = 1'b1;
    #1;  // still 6 time units before the next rising edge
    checks++;
    if ({duty_r, duty_g, duty_b} !== 24'h0 || busy !== 1'b0 || key_idx !== 4'd0) begin
      errors++; $display("FAIL async_reset: got duty=%h busy=%b key=%0d required duty=000000 busy=0 key=0", {duty_r, duty_g, duty_b}, busy, key_idx);
    end
    rst = 1'b0;
    step(2);
    checks++;
    if (busy !== 1'b0 || duty_r !== 8'd0) begin
      errors++; $display("FAIL post_reset_idle: got busy=%b r=%0d required busy=0 r=0", busy, duty_r);
    end
  endtask

  initial begin
    test_reset();
    test_fade_and_hold();
    test_full_cycle();
    test_pause();
    test_wrap_gating();
    test_start_stop();
    test_async_reset_mid_fade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
